// File: rtl/seq_barrel_shift_ctrl_if.sv
// Request/result handshake bundle for the sequenced mantissa shifter.
interface seq_barrel_shift_ctrl_if #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned AMT_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [AMT_W-1:0] in_amt;
  logic             in_dir;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_sticky;

  modport master (
    output in_valid, in_data, in_amt, in_dir, out_ready,
    input  in_ready, out_valid, out_data, out_sticky
  );

  modport slave (
    input  in_valid, in_data, in_amt, in_dir, out_ready,
    output in_ready, out_valid, out_data, out_sticky
  );
endinterface

// File: rtl/seq_barrel_shift_ctrl.sv
// Sequenced barrel shifter: one shared mux stage per clock (16,8,4,2,1),
// with sticky collection on right shifts for the round/pack stage.
module seq_barrel_shift_ctrl #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned AMT_W = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  seq_barrel_shift_ctrl_if.slave  bus
);
  localparam int unsigned STG_W = 3;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] work;
  logic [AMT_W-1:0] amt;
  logic             dir;
  logic [STG_W-1:0] stage;
  logic             sticky;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_sticky;

  logic [AMT_W-1:0] step_c;
  logic [WIDTH-1:0] shifted_c;
  logic             lost_c;

  // One stage of the shifter: step 2^stage applied only when that amount bit is set.
  always_comb begin
    step_c    = AMT_W'(1) << stage;
    shifted_c = work;
    lost_c    = 1'b0;
    if (amt[stage]) begin
      if (32'(step_c) >= WIDTH) begin
        shifted_c = '0;
        lost_c    = dir & (|work);
      end else if (dir) begin
        shifted_c = work >> step_c;
        lost_c    = |(work & ~({WIDTH{1'b1}} << step_c));
      end else begin
        shifted_c = work << step_c;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      work       <= '0;
      amt        <= '0;
      dir        <= 1'b0;
      stage      <= '0;
      sticky     <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sticky <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            work   <= bus.in_data;
            amt    <= bus.in_amt;
            dir    <= bus.in_dir;
            sticky <= 1'b0;
            stage  <= STG_W'(4);
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          work   <= shifted_c;
          sticky <= sticky | lost_c;
          if (stage == '0) begin
            out_valid  <= 1'b1;
            out_data   <= shifted_c;
            out_sticky <= sticky | lost_c;
            state      <= DONE;
          end else begin
            stage <= stage - STG_W'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_sticky <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Ready is a decode of the registered state, held low while in reset.
  assign bus.in_ready   = rst_n && (state == IDLE);
  assign bus.out_valid  = out_valid;
  assign bus.out_data   = out_data;
  assign bus.out_sticky = out_sticky;
endmodule

// File: tb/tb_seq_barrel_shift_ctrl.sv
// Self-checking bench for seq_barrel_shift_ctrl: bit-destination reference model,
// per-cycle output compare, directed cases plus randomized traffic.
module tb_seq_barrel_shift_ctrl;
  localparam int W = 24;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seq_barrel_shift_ctrl_if #(.WIDTH(W), .AMT_W(5)) bus ();

  seq_barrel_shift_ctrl #(.WIDTH(W), .AMT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [W-1:0] d;
    logic         s;
    int           acc;
  } exp_t;

  exp_t         exp_q[$];
  int           rises[$];
  int           errors = 0;
  int           checks = 0;
  int           cyc = 0;
  int           n_out = 0;
  logic [W-1:0] last_data;
  logic         last_sticky;
  bit           prev_valid = 1'b0;
  bit           rdy_mode = 1'b0;
  bit           rdy_val = 1'b1;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Each set input bit lands at i-a (right) or i+a (left); bits that fall off
  // the bottom of a right shift feed sticky.
  function automatic void model(input logic [W-1:0] d, input int a, input bit r,
                                output logic [W-1:0] q, output logic s);
    q = '0;
    s = 1'b0;
    for (int i = 0; i < W; i++) begin
      int j;
      j = r ? i - a : i + a;
      if (d[i]) begin
        if (j >= 0 && j < W) q[j] = 1'b1;
        else if (r) s = 1'b1;
      end
    end
  endfunction

  // out_ready driver: fixed level or random backpressure.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      bus.out_ready = rdy_mode ? 1'($urandom_range(0, 1)) : 1'(rdy_val);
    end
  end

  // Compare process: record accepts, check outputs every cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
      prev_valid = 1'b0;
    end else begin
      if (bus.in_valid && bus.in_ready) begin
        logic [W-1:0] q;
        logic         s;
        model(bus.in_data, int'(bus.in_amt), bus.in_dir, q, s);
        exp_q.push_back('{q, s, cyc + 1});
      end
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got data %h with no request pending", bus.out_data);
        end else begin
          chk("out_data", 32'(bus.out_data), 32'(exp_q[0].d));
          chk("out_sticky", 32'(bus.out_sticky), 32'(exp_q[0].s));
          if (!prev_valid) begin
            chk("latency", 32'(cyc - exp_q[0].acc), 32'd5);
            rises.push_back(cyc);
          end
          if (bus.out_ready) begin
            last_data   = bus.out_data;
            last_sticky = bus.out_sticky;
            void'(exp_q.pop_front());
            n_out++;
          end
        end
      end else begin
        chk("idle_data", 32'(bus.out_data), 32'd0);
        chk("idle_sticky", 32'(bus.out_sticky), 32'd0);
      end
      prev_valid = bus.out_valid;
    end
  end

  // Present a request (caller is just after a posedge); returns just after the accept edge.
  task automatic send(input logic [W-1:0] d, input logic [4:0] a, input logic r, input bit hold);
    bit ok;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_amt   = a;
    bus.in_dir   = r;
    ok = 1'b0;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1'b1;
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    if (!hold) bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(input int target, input int budget);
    for (int t = 0; t < budget && n_out < target; t++) @(posedge clk);
    if (n_out < target) chk("result_timeout", 32'(n_out), 32'(target));
    @(posedge clk);
    #1;
  endtask

  task automatic run1(input logic [W-1:0] d, input logic [4:0] a, input logic r);
    int base;
    base = n_out;
    send(d, a, r, 1'b0);
    wait_out(base + 1, 40);
  endtask

  task automatic wait_valid();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      if (bus.out_valid) ok = 1'b1;
    end
    if (!ok) chk("valid_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    logic [W-1:0] q;
    logic         s;
    int           base;

    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_amt   = '0;
    bus.in_dir   = 1'b0;

    // Hand-computed anchors for the model itself.
    model(24'h8000FF, 8, 1'b1, q, s);
    chk("model_r8_data", 32'(q), 32'h008000);
    chk("model_r8_sticky", 32'(s), 32'd1);
    model(24'h000003, 23, 1'b0, q, s);
    chk("model_l23_data", 32'(q), 32'h800000);
    chk("model_l23_sticky", 32'(s), 32'd0);

    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", 32'(bus.in_ready), 32'd0);
    chk("reset_out_data", 32'(bus.out_data), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("release_in_ready", 32'(bus.in_ready), 32'd1);

    run1(24'h000001, 5'd5, 1'b0);
    chk("left5_data", 32'(last_data), 32'h000020);
    chk("left5_sticky", 32'(last_sticky), 32'd0);

    run1(24'h8000FF, 5'd8, 1'b1);
    chk("right8_data", 32'(last_data), 32'h008000);
    chk("right8_sticky", 32'(last_sticky), 32'd1);
    run1(24'h800000, 5'd8, 1'b1);
    chk("right8b_data", 32'(last_data), 32'h008000);
    chk("right8b_sticky", 32'(last_sticky), 32'd0);

    run1(24'h000001, 5'd31, 1'b1);
    chk("right31_data", 32'(last_data), 32'd0);
    chk("right31_sticky", 32'(last_sticky), 32'd1);
    run1(24'hFFFFFF, 5'd24, 1'b0);
    chk("left24_data", 32'(last_data), 32'd0);
    chk("left24_sticky", 32'(last_sticky), 32'd0);

    // Zero amount under backpressure, with a competing request held on the input.
    rdy_val = 1'b0;
    base = n_out;
    send(24'hABCDEF, 5'd0, 1'b0, 1'b0);
    wait_valid();
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.in_data  = 24'h123456;
    bus.in_amt   = 5'd3;
    repeat (4) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    rdy_val      = 1'b1;
    @(negedge clk);
    chk("bp_still_done", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    chk("bp_ready_after", 32'(bus.in_ready), 32'd1);
    chk("bp_count", 32'(n_out), 32'(base + 1));
    chk("zero_amt_data", 32'(last_data), 32'hABCDEF);
    repeat (6) @(negedge clk);
    chk("bp_not_taken", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;

    // Back-to-back with in_valid held high.
    rises.delete();
    base = n_out;
    send(24'h00F00F, 5'd1, 1'b0, 1'b1);
    send(24'hF0F0F0, 5'd17, 1'b1, 1'b1);
    send(24'h000005, 5'd31, 1'b0, 1'b0);
    wait_out(base + 3, 60);
    chk("b2b_rises", 32'(rises.size()), 32'd3);
    if (rises.size() == 3) begin
      chk("b2b_gap1", 32'(rises[1] - rises[0]), 32'd7);
      chk("b2b_gap2", 32'(rises[2] - rises[1]), 32'd7);
    end

    // Reset during the third SHIFT cycle.
    send(24'h000001, 5'd3, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("rst_shift_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_shift_ready", 32'(bus.in_ready), 32'd0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    chk("rst_rel_ready", 32'(bus.in_ready), 32'd1);
    run1(24'h000003, 5'd2, 1'b0);
    chk("post_rst_data", 32'(last_data), 32'h00000C);

    // Reset while a result is waiting.
    rdy_val = 1'b0;
    send(24'h000005, 5'd1, 1'b1, 1'b0);
    wait_valid();
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("rst_done_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_done_data", 32'(bus.out_data), 32'd0);
    chk("rst_done_sticky", 32'(bus.out_sticky), 32'd0);
    rdy_val = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Randomized traffic with random backpressure.
    rdy_mode = 1'b1;
    base = n_out;
    for (int i = 0; i < 40; i++) begin
      send(W'($urandom), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'b0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    wait_out(base + 40, 2000);
    rdy_mode = 1'b0;
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
